// File: rtl/op2_pkg.sv
// Shared definitions for the operation2 operand loader.
// Holds default widths and the issue-state encoding.
package op2_pkg;

    localparam int OP_W_DEF  = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        I_IDLE,
        I_STB,
        I_WAIT_BUSY,
        I_WAIT_DONE
    } issue_st_e;

endpackage

// File: rtl/op2_stage_buf.sv
// Two-word staging buffer: packs two CPU words into four operands.
// Flush drops a partial or full set; take empties it after hand-off.
module op2_stage_buf
    import op2_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [2*OP_W-1:0] wdata_i,
    input  logic              wr_stb_i,
    input  logic              flush_i,
    input  logic              take_i,
    output logic              full_o,
    output logic [OP_W-1:0]   stage_a_o,
    output logic [OP_W-1:0]   stage_b_o,
    output logic [OP_W-1:0]   stage_c_o,
    output logic [OP_W-1:0]   stage_d_o
);

    logic            full_q, full_d;
    logic            ptr_q, ptr_d;
    logic [OP_W-1:0] a_q, a_d;
    logic [OP_W-1:0] b_q, b_d;
    logic [OP_W-1:0] c_q, c_d;
    logic [OP_W-1:0] d_q, d_d;
    logic            accept;

    assign accept = wr_stb_i & ~full_q & ~flush_i;

    // Next-state: flush beats everything, take empties, accept fills.
    always_comb begin
        full_d = full_q;
        ptr_d  = ptr_q;
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        d_d    = d_q;
        if (flush_i) begin
            full_d = 1'b0;
            ptr_d  = 1'b0;
        end else if (take_i) begin
            full_d = 1'b0;
        end else if (accept) begin
            if (!ptr_q) begin
                a_d = wdata_i[OP_W-1:0];
                b_d = wdata_i[2*OP_W-1:OP_W];
            end else begin
                c_d    = wdata_i[OP_W-1:0];
                d_d    = wdata_i[2*OP_W-1:OP_W];
                full_d = 1'b1;
            end
            ptr_d = ~ptr_q;
        end
    end

    // Staging registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            ptr_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
        end else begin
            full_q <= full_d;
            ptr_q  <= ptr_d;
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            d_q    <= d_d;
        end
    end

    assign full_o    = full_q;
    assign stage_a_o = a_q;
    assign stage_b_o = b_q;
    assign stage_c_o = c_q;
    assign stage_d_o = d_q;

endmodule

// File: rtl/op2_operand_loader.sv
// Loads four operands from the CPU and issues them to operation2.
// Staging is double-buffered against the issue FSM.
module op2_operand_loader
    import op2_pkg::*;
#(
    parameter int OP_W  = OP_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2*OP_W-1:0] cpu_wdata,
    input  logic              cpu_wr_STB,
    output logic              cpu_BUSY,
    input  logic              flush,
    output logic [OP_W-1:0]   input_a,
    output logic [OP_W-1:0]   input_b,
    output logic [OP_W-1:0]   input_c,
    output logic [OP_W-1:0]   input_d,
    output logic              op2_input_STB,
    input  logic              op2_BUSY,
    output logic [CNT_W-1:0]  issued_count
);

    issue_st_e        state_q;
    logic             stb_q;
    logic [OP_W-1:0]  a_q, b_q, c_q, d_q;
    logic [CNT_W-1:0] cnt_q;
    logic             full;
    logic             take;
    logic [OP_W-1:0]  st_a, st_b, st_c, st_d;

    assign take = (state_q == I_IDLE) & full;

    op2_stage_buf #(
        .OP_W (OP_W)
    ) u_stage (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wdata_i   (cpu_wdata),
        .wr_stb_i  (cpu_wr_STB),
        .flush_i   (flush),
        .take_i    (take),
        .full_o    (full),
        .stage_a_o (st_a),
        .stage_b_o (st_b),
        .stage_c_o (st_c),
        .stage_d_o (st_d)
    );

    // Issue FSM: latch operands, strobe, then follow op2_BUSY high-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= I_IDLE;
            stb_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                I_IDLE: begin
                    if (full) begin
                        a_q     <= st_a;
                        b_q     <= st_b;
                        c_q     <= st_c;
                        d_q     <= st_d;
                        stb_q   <= 1'b1;
                        state_q <= I_STB;
                    end
                end
                I_STB: begin
                    if (!op2_BUSY) begin
                        stb_q   <= 1'b0;
                        state_q <= I_WAIT_BUSY;
                    end
                end
                I_WAIT_BUSY: begin
                    if (op2_BUSY) begin
                        state_q <= I_WAIT_DONE;
                    end
                end
                I_WAIT_DONE: begin
                    if (!op2_BUSY) begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= I_IDLE;
                    end
                end
            endcase
        end
    end

    assign cpu_BUSY      = full;
    assign op2_input_STB = stb_q;
    assign input_a       = a_q;
    assign input_b       = b_q;
    assign input_c       = c_q;
    assign input_d       = d_q;
    assign issued_count  = cnt_q;

endmodule

// File: doc/op2_operand_loader.md
OP2_OPERAND_LOADER -- requirements
Module: op2_operand_loader

Interface
REQ-001 SHALL provide parameter OP_W, default 16, operand width presented to operation2.
REQ-002 SHALL provide parameter CNT_W, default 8, width of issued-operation counter.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cpu_wdata  input  2*OP_W  packed operand word from CPU side.
REQ-006 SHALL have port cpu_wr_STB  input  1  CPU write strobe.
REQ-007 SHALL have port cpu_BUSY  output  1  loader cannot accept a write.
REQ-008 SHALL have port flush  input  1  discard partially/fully staged operands.
REQ-009 SHALL have ports input_a, input_b, input_c, input_d  output  OP_W each  operands to operation2.
REQ-010 SHALL have port op2_input_STB  output  1  request strobe to operation2.
REQ-011 SHALL have port op2_BUSY  input  1  operation2 busy.
REQ-012 SHALL have port issued_count  output  CNT_W  completed operations, wraps.

Function
REQ-013 SHALL accept a CPU word on any edge where cpu_wr_STB=1 and cpu_BUSY=0 and flush=0.
REQ-014 SHALL store first accepted word as stage_a=wdata[OP_W-1:0], stage_b=wdata[2*OP_W-1:OP_W]; second as stage_c, stage_d (same split); word pointer toggles per accept.
REQ-015 SHALL mark staging full after second word; cpu_BUSY SHALL be 1 exactly while staging full.
REQ-016 SHALL run issue FSM states I_IDLE, I_STB, I_WAIT_BUSY, I_WAIT_DONE.
REQ-017 I_IDLE with staging full: SHALL copy stage_a..d to input_a..d, set op2_input_STB=1, clear staging full, go I_STB (one edge after word-two accept).
REQ-018 I_STB: on edge with op2_BUSY=0 the transfer SHALL count as accepted; STB cleared, go I_WAIT_BUSY; otherwise hold STB.
REQ-019 I_WAIT_BUSY: op2_BUSY=1 -> I_WAIT_DONE.
REQ-020 I_WAIT_DONE: op2_BUSY=0 -> I_IDLE, issued_count+1 (255->0 wrap at CNT_W=8).
REQ-021 input_a..d SHALL stay constant from I_STB entry until return to I_IDLE (operation2 samples c/d late).
REQ-022 Staging SHALL accept the next two words while issue FSM is not idle (double buffering).
REQ-023 flush SHALL clear staging full and word pointer only; issue FSM, outputs, counter unaffected.
REQ-024 flush with cpu_wr_STB same cycle: flush wins, word dropped.
REQ-025 Staging becoming full in I_WAIT_DONE's exit cycle: transfer SHALL occur on the following I_IDLE edge, never same edge.

Reset
REQ-026 While rst=0 at an edge: op2_input_STB=0, cpu_BUSY=0, input_a..d=0, issued_count=0, staging empty, pointer=0, FSM=I_IDLE.
REQ-027 Reset mid-operation SHALL abandon any staged or in-flight operation without incrementing issued_count.
REQ-028 First accepting edge SHALL be the first edge with rst=1.

Structure
REQ-029 Shared package op2_pkg SHALL hold OP_W default and issue-state enum.
REQ-030 Staging buffer SHALL be a sub-module op2_stage_buf (two-word pack, full flag, flush); FSM in top.

Verification
REQ-031 Write 0x0002_0001 then 0x0004_0003, op2_BUSY=0 -> STB high one cycle later with a=1,b=2,c=3,d=4; STB low after one cycle.
REQ-032 Hold op2_BUSY=1 during I_STB for 5 cycles -> STB held, operands stable; release -> accepted, count unchanged until BUSY high-then-low, then issued_count=1.
REQ-033 Stage second set (0x00060005, 0x00080007) during I_WAIT_DONE -> cpu_BUSY=1 after second word; on BUSY fall second issue with a=5..d=8, cpu_BUSY drops.
REQ-034 Write one word, assert flush, write 0x000A_0009 and 0x000C_000B -> issued operands 9,10,11,12.
REQ-035 rst=0 during I_WAIT_DONE -> all outputs zero next edge, issued_count=0; 256 completions from reset -> issued_count=0.
